// File: rtl/bnn_inst_fetch_if.sv
// Bundle of host-load, controller and instruction-SRAM signals for the
// BNN instruction-fetch front end. The slave side is the fetch unit, the
// master side is whatever surrounds it (host, controller, SRAM).
interface bnn_inst_fetch_if #(
  parameter int AW = 11,
  parameter int IW = 16
);
  // host program loading
  logic          start;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [IW-1:0] host_wdata;
  logic          host_ready;

  // controller side
  logic [AW-1:0] ctrl_addr;
  logic          ext_stall;
  logic [IW-1:0] inst;
  logic          pause;
  logic          done;
  logic [15:0]   inst_count;

  // instruction SRAM side
  logic [AW-1:0] isram_addr;
  logic          isram_cen;
  logic          isram_wen;
  logic [IW-1:0] isram_d;
  logic [IW-1:0] isram_q;

  modport slave (
    input  start, host_we, host_addr, host_wdata, ctrl_addr, ext_stall, isram_q,
    output host_ready, inst, pause, done, inst_count,
           isram_addr, isram_cen, isram_wen, isram_d
  );

  modport master (
    output start, host_we, host_addr, host_wdata, ctrl_addr, ext_stall, isram_q,
    input  host_ready, inst, pause, done, inst_count,
           isram_addr, isram_cen, isram_wen, isram_d
  );
endinterface

// File: rtl/bnn_inst_fetch.sv
// Instruction-fetch front end for the BNN controller. Shares the 2K x 16
// instruction SRAM between host program loading (only while idle) and
// run-time fetch, hides the SRAM's one-cycle read latency behind an
// ISSUE/EXEC pair, stops on the HALT opcode and counts retired instructions.
module bnn_inst_fetch #(
  parameter int       AW      = 11,
  parameter int       IW      = 16,
  parameter bit [4:0] HALT_OP = 5'b11111
) (
  input logic              clk,
  input logic              rst,
  bnn_inst_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] instCount_q;

  logic isHalt;
  logic retire;

  // The SRAM output is held while cen is high, so in EXEC isram_q is the
  // word fetched during the preceding ISSUE for as long as we stay here.
  assign isHalt = (bus.isram_q[IW-1 -: 5] == HALT_OP);
  assign retire = (state_q == EXEC) && !isHalt && !bus.ext_stall;

  // Sequencer and retired-instruction counter; HALT wins over a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instCount_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_q <= ISSUE;
        ISSUE:   state_q <= EXEC;
        EXEC: begin
          if (isHalt)              state_q <= HALT;
          else if (!bus.ext_stall) state_q <= ISSUE;
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
      if (retire && (instCount_q != 16'hFFFF)) begin
        instCount_q <= instCount_q + 16'd1;
      end
    end
  end

  // Controller and SRAM outputs decoded from the current state and inputs.
  always_comb begin
    bus.host_ready = 1'b0;
    bus.pause      = 1'b1;
    bus.inst       = '0;
    bus.done       = 1'b0;
    bus.isram_cen  = 1'b1;
    bus.isram_wen  = 1'b1;
    bus.isram_addr = '0;
    bus.isram_d    = '0;
    case (state_q)
      IDLE: begin
        bus.host_ready = 1'b1;
        if (bus.host_we) begin
          bus.isram_cen  = 1'b0;
          bus.isram_wen  = 1'b0;
          bus.isram_addr = bus.host_addr;
          bus.isram_d    = bus.host_wdata;
        end
      end
      ISSUE: begin
        bus.isram_cen  = 1'b0;
        bus.isram_addr = bus.ctrl_addr;
      end
      EXEC: begin
        if (retire) begin
          bus.pause = 1'b0;
          bus.inst  = bus.isram_q;
        end
      end
      HALT: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.pause = 1'b1;
      end
    endcase
  end

  assign bus.inst_count = instCount_q;

endmodule

// File: tb/tb_bnn_inst_fetch.sv
// Self-checking bench for bnn_inst_fetch: a behavioural SRAM, a controller
// model that steps pc1 on every retirement, and a queue of expected
// instructions filled as programs are loaded and drained as they retire.
module tb_bnn_inst_fetch;

  logic clk;
  logic rst;

  bnn_inst_fetch_if #(.AW(11), .IW(16)) bus ();

  bnn_inst_fetch #(.AW(11), .IW(16), .HALT_OP(5'b11111)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] sramMem [0:2047];
  logic [15:0] expQ[$];
  logic [15:0] expCount;
  int compared;
  int mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction SRAM: write when cen/wen low, one-cycle read, hold otherwise.
  always @(posedge clk) begin
    if (!bus.isram_cen) begin
      if (!bus.isram_wen) sramMem[bus.isram_addr] <= bus.isram_d;
      else                bus.isram_q <= sramMem[bus.isram_addr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then let them settle.
  task automatic applyStimulus(input logic rstIn, input logic startIn, input logic weIn,
                               input logic [10:0] addrIn, input logic [15:0] dataIn,
                               input logic [10:0] ctrlIn, input logic stallIn);
    @(negedge clk);
    rst            = rstIn;
    bus.start      = startIn;
    bus.host_we    = weIn;
    bus.host_addr  = addrIn;
    bus.host_wdata = dataIn;
    bus.ctrl_addr  = ctrlIn;
    bus.ext_stall  = stallIn;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 16'h0000, 11'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 11'd0, 1'b0);
    expCount = 16'h0000;
    checkOutput("rst_pause",      bus.pause,      1);
    checkOutput("rst_inst",       bus.inst,       0);
    checkOutput("rst_done",       bus.done,       0);
    checkOutput("rst_host_ready", bus.host_ready, 1);
    checkOutput("rst_cen",        bus.isram_cen,  1);
    checkOutput("rst_wen",        bus.isram_wen,  1);
    checkOutput("rst_addr",       bus.isram_addr, 0);
    checkOutput("rst_d",          bus.isram_d,    0);
    checkOutput("rst_count",      bus.inst_count, 0);
  endtask

  task automatic hostWrite(input logic [10:0] addr, input logic [15:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, data, 11'd0, 1'b0);
    checkOutput("host_cen",   bus.isram_cen,  0);
    checkOutput("host_wen",   bus.isram_wen,  0);
    checkOutput("host_addr",  bus.isram_addr, {21'd0, addr});
    checkOutput("host_d",     bus.isram_d,    {16'd0, data});
    checkOutput("host_ready", bus.host_ready, 1);
  endtask

  // Start the fetcher and follow it cycle by cycle until HALT or maxCycles.
  task automatic runProgram(input logic [10:0] startAddr, input bit expectHalt, input int maxCycles,
                            input int jumpFrom, input logic [10:0] jumpTo,
                            input int stallAt, input int stallLen, input int expFirst,
                            input bit startWe, input logic [10:0] weAddr, input logic [15:0] weData);
    logic [10:0] ctrl;
    bit retiredLast;
    bit haltSeen;
    bit firstSeen;
    ctrl        = startAddr;
    retiredLast = 1'b0;
    haltSeen    = 1'b0;
    firstSeen   = 1'b0;
    applyStimulus(1'b0, 1'b1, startWe, weAddr, weData, ctrl, 1'b0);
    checkOutput("start_host_ready", bus.host_ready, 1);
    checkOutput("start_pause",      bus.pause,      1);
    checkOutput("start_count",      bus.inst_count, {16'd0, expCount});
    if (startWe) begin
      checkOutput("start_we_cen", bus.isram_cen, 0);
      checkOutput("start_we_wen", bus.isram_wen, 0);
    end
    for (int cyc = 1; cyc <= maxCycles; cyc++) begin
      if (retiredLast) begin
        if (int'(ctrl) == jumpFrom) ctrl = jumpTo;
        else                        ctrl = ctrl + 11'd1;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, ctrl,
                    (cyc >= stallAt) && (cyc < stallAt + stallLen));
      retiredLast = 1'b0;
      checkOutput("inst_count", bus.inst_count, {16'd0, expCount});
      if (bus.done) begin
        haltSeen = 1'b1;
        checkOutput("halt_pause", bus.pause,     1);
        checkOutput("halt_inst",  bus.inst,      0);
        checkOutput("halt_cen",   bus.isram_cen, 1);
        break;
      end
      checkOutput("busy_host_ready", bus.host_ready, 0);
      if (!bus.isram_cen && bus.isram_wen) begin
        checkOutput("issue_addr", bus.isram_addr, {21'd0, ctrl});
      end
      if (!bus.pause) begin
        if (!firstSeen) begin
          firstSeen = 1'b1;
          checkOutput("first_retire_cycle", cyc, expFirst);
        end
        if (expQ.size() == 0) checkOutput("retire_queue_size", expQ.size(), 1);
        else                  checkOutput("inst", bus.inst, {16'd0, expQ.pop_front()});
        expCount    = (expCount == 16'hFFFF) ? 16'hFFFF : expCount + 16'd1;
        retiredLast = 1'b1;
      end else begin
        checkOutput("paused_inst_null", bus.inst, 0);
      end
    end
    checkOutput("halt_reached",       {31'd0, haltSeen}, {31'd0, expectHalt});
    checkOutput("scoreboard_drained", expQ.size(), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    expCount   = 16'h0000;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.ctrl_addr  = '0;
    bus.ext_stall  = 1'b0;

    // Host load, with the last write sharing a cycle with start
    doReset();
    hostWrite(11'd0, 16'h0801);
    hostWrite(11'd1, 16'h2101);
    expQ.push_back(16'h0801);
    expQ.push_back(16'h2101);
    runProgram(11'd0, 1'b1, 20, -1, 11'd0, 0, 0, 2, 1'b1, 11'd2, 16'hF800);
    checkOutput("load_final_count", bus.inst_count, 2);

    // Sequential run to HALT, then start must not restart it
    doReset();
    for (int i = 0; i < 4; i++) begin
      hostWrite(11'(i), 16'(i + 1));
      expQ.push_back(16'(i + 1));
    end
    hostWrite(11'd4, 16'hF800);
    runProgram(11'd0, 1'b1, 40, -1, 11'd0, 0, 0, 2, 1'b0, 11'd0, 16'h0000);
    checkOutput("seq_final_count", bus.inst_count, 4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 11'd0, 16'h0000, 11'd0, 1'b0);
      checkOutput("sticky_done",  bus.done,      1);
      checkOutput("sticky_pause", bus.pause,     1);
      checkOutput("sticky_cen",   bus.isram_cen, 1);
      checkOutput("sticky_count", bus.inst_count, 4);
    end

    // Stall for three EXEC cycles
    doReset();
    hostWrite(11'd0, 16'h4080);
    hostWrite(11'd1, 16'hF800);
    expQ.push_back(16'h4080);
    runProgram(11'd0, 1'b1, 30, -1, 11'd0, 2, 3, 5, 1'b0, 11'd0, 16'h0000);

    // Jump from 10 back to 3
    doReset();
    hostWrite(11'd8,  16'h1008);
    hostWrite(11'd9,  16'h2009);
    hostWrite(11'd10, 16'h300A);
    hostWrite(11'd3,  16'h4003);
    hostWrite(11'd4,  16'hF800);
    expQ.push_back(16'h1008);
    expQ.push_back(16'h2009);
    expQ.push_back(16'h300A);
    expQ.push_back(16'h4003);
    runProgram(11'd8, 1'b1, 40, 10, 11'd3, 0, 0, 2, 1'b0, 11'd0, 16'h0000);

    // Reset mid-EXEC with seven retirements, plus a host write that must be ignored
    doReset();
    for (int i = 0; i < 16; i++) hostWrite(11'(i), 16'(i + 1));
    for (int i = 0; i < 7; i++) expQ.push_back(16'(i + 1));
    runProgram(11'd0, 1'b0, 15, -1, 11'd0, 0, 0, 2, 1'b0, 11'd0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 11'd5, 16'hBEEF, 11'd7, 1'b1);
    checkOutput("exec_we_wen",        bus.isram_wen,  1);
    checkOutput("exec_we_cen",        bus.isram_cen,  1);
    checkOutput("exec_host_ready",    bus.host_ready, 0);
    checkOutput("exec_stall_pause",   bus.pause,      1);
    checkOutput("exec_count_seven",   bus.inst_count, 7);
    applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 16'h0000, 11'd7, 1'b1);
    checkOutput("rst_cycle_pause",    bus.pause,      1);
    applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 11'd7, 1'b0);
    checkOutput("after_rst_pause",    bus.pause,      1);
    checkOutput("after_rst_count",    bus.inst_count, 0);
    checkOutput("after_rst_cen",      bus.isram_cen,  1);
    checkOutput("after_rst_ready",    bus.host_ready, 1);
    checkOutput("no_write_in_exec",   sramMem[5],     16'h0006);

    // Counter saturation starting just below the limit
    doReset();
    for (int i = 0; i < 4; i++) begin
      hostWrite(11'(i), 16'(i + 1));
      expQ.push_back(16'(i + 1));
    end
    hostWrite(11'd4, 16'hF800);
    force dut.instCount_q = 16'hFFFD;
    #1;
    release dut.instCount_q;
    expCount = 16'hFFFD;
    runProgram(11'd0, 1'b1, 40, -1, 11'd0, 0, 0, 2, 1'b0, 11'd0, 16'h0000);
    checkOutput("saturated_count", bus.inst_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
